// File: rtl/dram_wr_rd_sequencer.sv
// Button-started test sequencer: writes {a,~a,a,~a} to all 16 words of a DRAM macro, then reads each back.
// Optional UART_REPORT_EN streams every captured word as two 8N1 bytes (high byte first).
module dram_wr_rd_sequencer #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int WR_PULSE_CYC = 4,
  parameter int SENSE_CYC    = 4,
  parameter int BAUD_DIV     = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IO_EN_button,
  input  logic [15:0] DRAM16_data,
  input  logic        SW2,
  input  logic        SW3,
  input  logic        SW4,
  input  logic        SW5,
  input  logic        SW6,
  input  logic        SW7,
  input  logic        SW8,
  input  logic        SW9,
  input  logic        SW10,
  input  logic        SW11,
  input  logic        SW12,
  output logic        RD_DONE_LED,
  output logic        WT_DONE_LED,
  output logic [2:0]  PC_data,
  output logic [1:0]  PC_D_IN,
  output logic [1:0]  PC_R_AD,
  output logic [1:0]  LIM_SEL,
  output logic        DE_ADD3,
  output logic [15:0] LIM_IN,
  output logic        ADD_IN,
  output logic        ADD_VALID_IN,
  output logic [15:0] D_IN,
  output logic        DATA_VALID_IN,
  output logic        WRI_EN,
  output logic [15:0] R_AD,
  output logic        RD_EN,
  output logic        VSAEN,
  output logic        REF_WWL,
  output logic        clk_out,
  output logic        uart_txd
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, WR_PULSE, WR_GAP,
    RD_SETUP, RD_SENSE, RD_CAPTURE, RD_TX, RD_REF, DONE
  } state_t;

  typedef struct packed {
    logic        add_in;
    logic        add_valid;
    logic        data_valid;
    logic        wri_en;
    logic        rd_en;
    logic        vsaen;
    logic        ref_wwl;
    logic [15:0] r_ad;
  } drv_t;

  localparam int CMAX0 = (WR_PULSE_CYC > SENSE_CYC) ? WR_PULSE_CYC : SENSE_CYC;
  localparam int CMAX  = (CMAX0 > 4) ? CMAX0 : 4;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int DBW   = $clog2(DEBOUNCE_CYC + 1);

  assign LIM_SEL = {SW3, SW2};
  assign PC_data = {SW6, SW5, SW4};
  assign PC_D_IN = {SW8, SW7};
  assign PC_R_AD = {SW10, SW9};
  assign DE_ADD3 = SW11;
  assign LIM_IN  = 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_out <= 1'b0;
    else     clk_out <= ~clk_out;
  end

  // Sync flops reset to "released" so a button held through reset still needs a full low run.
  logic           btn_s1, btn_s2, armed, start_p;
  logic [DBW-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      armed   <= 1'b1;
      db_cnt  <= '0;
      start_p <= 1'b0;
    end else begin
      btn_s1  <= IO_EN_button;
      btn_s2  <= btn_s1;
      start_p <= 1'b0;
      if (btn_s2) begin
        armed  <= 1'b1;
        db_cnt <= '0;
      end else if (armed) begin
        if (db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
          start_p <= 1'b1;
          armed   <= 1'b0;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    addr, addr_n;
  logic          wt_led, wt_n, rd_led, rd_n;
  logic [15:0]   d_in_q, d_in_n;
  drv_t          drv_q;
  logic          tx_last;

  // Macro strobes are registered from the next state so they are glitch-free and line up with it.
  function automatic drv_t decode(state_t s, logic [1:0] c, logic [3:0] a);
    drv_t d = '0;
    d.add_valid  = (s == WR_ADDR);
    d.add_in     = (s == WR_ADDR) && a[2'd3 - c];
    d.data_valid = (s == WR_DATA);
    d.wri_en     = (s == WR_PULSE);
    d.vsaen      = (s == RD_SENSE);
    d.ref_wwl    = (s == RD_REF);
    d.rd_en      = (s == RD_SETUP) || (s == RD_SENSE) || (s == RD_CAPTURE) || (s == RD_TX);
    d.r_ad       = d.rd_en ? (16'h1 << a) : 16'h0;
    return d;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    wt_n    = wt_led;
    rd_n    = rd_led;
    d_in_n  = d_in_q;
    case (state)
      IDLE, DONE: if (start_p) begin
        wt_n    = 1'b0;
        rd_n    = 1'b0;
        addr_n  = 4'd0;
        cnt_n   = '0;
        state_n = SW12 ? RD_SETUP : WR_ADDR;
      end
      WR_ADDR: if (cnt == CW'(3)) begin
        cnt_n   = '0;
        d_in_n  = {addr, ~addr, addr, ~addr};
        state_n = WR_DATA;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      WR_DATA: state_n = WR_PULSE;
      WR_PULSE: if (cnt == CW'(WR_PULSE_CYC - 1)) begin
        cnt_n   = '0;
        state_n = WR_GAP;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      WR_GAP: begin
        addr_n  = addr + 4'd1;
        state_n = WR_ADDR;
        if (addr == 4'hF) begin
          wt_n    = 1'b1;
          state_n = RD_SETUP;
        end
      end
      RD_SETUP: state_n = RD_SENSE;
      RD_SENSE: if (cnt == CW'(SENSE_CYC - 1)) begin
        cnt_n   = '0;
        state_n = RD_CAPTURE;
      end else begin
        cnt_n = cnt + CW'(1);
      end
`ifdef UART_REPORT_EN
      RD_CAPTURE: state_n = RD_TX;
      RD_TX:      if (tx_last) state_n = RD_REF;
`else
      RD_CAPTURE: state_n = RD_REF;
`endif
      RD_REF: begin
        addr_n  = addr + 4'd1;
        state_n = RD_SETUP;
        if (addr == 4'hF) begin
          rd_n    = 1'b1;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= 4'd0;
      wt_led <= 1'b0;
      rd_led <= 1'b0;
      d_in_q <= 16'h0;
      drv_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr   <= addr_n;
      wt_led <= wt_n;
      rd_led <= rd_n;
      d_in_q <= d_in_n;
      drv_q  <= decode(state_n, cnt_n[1:0], addr_n);
    end
  end

  assign WT_DONE_LED   = wt_led;
  assign RD_DONE_LED   = rd_led;
  assign D_IN          = d_in_q;
  assign ADD_IN        = drv_q.add_in;
  assign ADD_VALID_IN  = drv_q.add_valid;
  assign DATA_VALID_IN = drv_q.data_valid;
  assign WRI_EN        = drv_q.wri_en;
  assign RD_EN         = drv_q.rd_en;
  assign VSAEN         = drv_q.vsaen;
  assign REF_WWL       = drv_q.ref_wwl;
  assign R_AD          = drv_q.r_ad;

`ifdef UART_REPORT_EN
  // The 20-bit shift register doubles as the capture register: two full 8N1 frames, sent from bit 0.
  localparam int BDW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  logic [BDW-1:0] baud_cnt;
  logic [4:0]     bit_idx;
  logic [19:0]    tx_sh;
  logic           baud_end;

  assign baud_end = (baud_cnt == BDW'(BAUD_DIV - 1));
  assign tx_last  = baud_end && (bit_idx == 5'd19);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= 5'd0;
      tx_sh    <= '1;
    end else if (state == RD_CAPTURE) begin
      baud_cnt <= '0;
      bit_idx  <= 5'd0;
      tx_sh    <= {1'b1, DRAM16_data[7:0], 1'b0, 1'b1, DRAM16_data[15:8], 1'b0};
    end else if (state == RD_TX) begin
      if (baud_end) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + 5'd1;
        tx_sh    <= {1'b1, tx_sh[19:1]};
      end else begin
        baud_cnt <= baud_cnt + BDW'(1);
      end
    end
  end

  assign uart_txd = tx_sh[0];
`else
  // Read data has no consumer without the UART report; sink it explicitly.
  logic unused_rd;
  assign unused_rd = ^{DRAM16_data, 32'(BAUD_DIV)};
  assign tx_last   = 1'b0;
  assign uart_txd  = 1'b1;
`endif

endmodule

// File: tb/tb_dram_wr_rd_sequencer.sv
// Bench for dram_wr_rd_sequencer: phase-arithmetic model checked every cycle plus directed literal checks.
module tb_dram_wr_rd_sequencer;
  localparam int DEB = 16;

  logic        clk = 1'b0, rst = 1'b1, btn = 1'b1;
  logic [15:0] dram = 16'hA5A5;
  logic [12:2] sw = '0;
  logic        RD_DONE_LED, WT_DONE_LED, DE_ADD3, ADD_IN, ADD_VALID_IN, DATA_VALID_IN;
  logic        WRI_EN, RD_EN, VSAEN, REF_WWL, clk_out, uart_txd;
  logic [2:0]  PC_data;
  logic [1:0]  PC_D_IN, PC_R_AD, LIM_SEL;
  logic [15:0] LIM_IN, D_IN, R_AD;

  dram_wr_rd_sequencer #(.DEBOUNCE_CYC(DEB), .WR_PULSE_CYC(4), .SENSE_CYC(4), .BAUD_DIV(868)) dut (
    .clk(clk), .rst(rst), .IO_EN_button(btn), .DRAM16_data(dram),
    .SW2(sw[2]), .SW3(sw[3]), .SW4(sw[4]), .SW5(sw[5]), .SW6(sw[6]), .SW7(sw[7]),
    .SW8(sw[8]), .SW9(sw[9]), .SW10(sw[10]), .SW11(sw[11]), .SW12(sw[12]),
    .RD_DONE_LED(RD_DONE_LED), .WT_DONE_LED(WT_DONE_LED), .PC_data(PC_data), .PC_D_IN(PC_D_IN),
    .PC_R_AD(PC_R_AD), .LIM_SEL(LIM_SEL), .DE_ADD3(DE_ADD3), .LIM_IN(LIM_IN), .ADD_IN(ADD_IN),
    .ADD_VALID_IN(ADD_VALID_IN), .D_IN(D_IN), .DATA_VALID_IN(DATA_VALID_IN), .WRI_EN(WRI_EN),
    .R_AD(R_AD), .RD_EN(RD_EN), .VSAEN(VSAEN), .REF_WWL(REF_WWL), .clk_out(clk_out), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a press fires when the button, seen two clocks late, has been low for exactly DEB samples.
  // A sequence then runs on a cycle index t: 16 words x 10 write cycles, then 16 words x 7 read cycles.
  logic        m_s1, m_s2;
  int          lowrun, t;
  bit          pending, active, ro, m_wt, m_rd, m_co;
  logic [15:0] m_din;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; lowrun = 0; pending = 0; active = 0; ro = 0;
      m_wt = 0; m_rd = 0; m_co = 0; m_din = 16'h0; t = 0;
    end else begin
      m_co = ~m_co;
      if (pending && !active) begin
        active = 1; t = 0; ro = sw[12]; m_wt = 0; m_rd = 0;
      end else if (active) begin
        t++;
        if (!ro && t == 160) m_wt = 1;
        if (t == (ro ? 112 : 272)) begin active = 0; m_rd = 1; end
      end
      if (active && !ro && t < 160 && (t % 10) == 4) begin
        logic [3:0] a;
        a = 4'(t / 10);
        m_din = {a, ~a, a, ~a};
      end
      if (m_s2 == 1'b0) lowrun++; else lowrun = 0;
      pending = (lowrun == DEB);
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  int n_wri = 0, n_dv = 0, n_vsa = 0, n_ref = 0;

  always @(negedge clk) begin : cmp
    logic        e_av, e_ai, e_dv, e_we, e_re, e_vs, e_rf;
    logic [15:0] e_rad;
    int          w, p, r;
    e_av = 0; e_ai = 0; e_dv = 0; e_we = 0; e_re = 0; e_vs = 0; e_rf = 0; e_rad = 16'h0;
    if (active) begin
      if (!ro && t < 160) begin
        w = t / 10; p = t % 10;
        e_av = (p < 4);
        if (p < 4) e_ai = ((w >> (3 - p)) & 1) != 0;
        e_dv = (p == 4);
        e_we = (p >= 5 && p <= 8);
      end else begin
        r = ro ? t : t - 160;
        w = r / 7; p = r % 7;
        e_re = (p <= 5);
        if (p <= 5) e_rad = 16'h1 << w;
        e_vs = (p >= 1 && p <= 4);
        e_rf = (p == 6);
      end
    end
    chk("add_valid", ADD_VALID_IN, e_av);
    if (e_av) chk("add_in", ADD_IN, e_ai);
    chk("data_valid", DATA_VALID_IN, e_dv);
    chk("wri_en", WRI_EN, e_we);
    chk("rd_en", RD_EN, e_re);
    chk("r_ad", R_AD, e_rad);
    chk("vsaen", VSAEN, e_vs);
    chk("ref_wwl", REF_WWL, e_rf);
    chk("d_in", D_IN, m_din);
    chk("wt_led", WT_DONE_LED, m_wt);
    chk("rd_led", RD_DONE_LED, m_rd);
    chk("clk_out", clk_out, m_co);
    chk("uart_txd", uart_txd, 1'b1);
    chk("lim_in", LIM_IN, 16'h0);
    chk("pass_sw", {LIM_SEL, PC_data, PC_D_IN, PC_R_AD, DE_ADD3},
        {sw[3], sw[2], sw[6], sw[5], sw[4], sw[8], sw[7], sw[10], sw[9], sw[11]});
    n_wri += int'(WRI_EN); n_dv += int'(DATA_VALID_IN);
    n_vsa += int'(VSAEN);  n_ref += int'(REF_WWL);
  end

  int tt;
  task automatic press_to_t0();
    @(negedge clk); btn = 1'b0;
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk);
    tt = 0;
  endtask
  task automatic go_t(input int k);
    while (tt < k) begin @(negedge clk); tt++; end
  endtask

  logic [10:0] pats [3];
  int s_wri, s_dv, s_vsa, s_ref;

  initial begin
    pats = '{11'h555, 11'h2AA, 11'h3C5};
    repeat (10) @(negedge clk);
    #1;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_wt", WT_DONE_LED, 1'b0);
    chk("rst_r_ad", R_AD, 16'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); chk("clk_out_hi", clk_out, 1'b1);
    @(negedge clk); chk("clk_out_lo", clk_out, 1'b0);

    foreach (pats[i]) begin
      sw[12:2] = pats[i]; #1;
      chk("lim_sel", LIM_SEL, {pats[i][1], pats[i][0]});
      chk("pc_data", PC_data, {pats[i][4], pats[i][3], pats[i][2]});
      chk("pc_d_in", PC_D_IN, {pats[i][6], pats[i][5]});
      chk("pc_r_ad", PC_R_AD, {pats[i][8], pats[i][7]});
      chk("de_add3", DE_ADD3, pats[i][9]);
      @(negedge clk);
    end
    sw = '0;

    // Short low pulse must not start anything
    @(negedge clk); btn = 1'b0;
    repeat (DEB - 4) @(negedge clk);
    btn = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_wt", WT_DONE_LED, 1'b0);
    chk("glitch_rd", RD_DONE_LED, 1'b0);
    chk("glitch_wri", n_wri, 0);

    // Full write + read
    s_wri = n_wri; s_dv = n_dv; s_vsa = n_vsa; s_ref = n_ref;
    press_to_t0();
    for (int k = 0; k < 4; k++) begin go_t(k); chk("w0_add_in", ADD_IN, 1'b0); end
    go_t(4);  chk("w0_d_in", D_IN, 16'h0F0F); chk("w0_dv", DATA_VALID_IN, 1'b1);
    go_t(10); btn = 1'b1;
    go_t(50); chk("w5_b3", ADD_IN, 1'b0);
    go_t(51); chk("w5_b2", ADD_IN, 1'b1);
    go_t(52); chk("w5_b1", ADD_IN, 1'b0);
    go_t(53); chk("w5_b0", ADD_IN, 1'b1);
    go_t(54); chk("w5_d_in", D_IN, 16'h5A5A);
    go_t(159); chk("wt_before", WT_DONE_LED, 1'b0);
    go_t(160); chk("wt_rise", WT_DONE_LED, 1'b1); chk("rd0_r_ad", R_AD, 16'h0001);
    go_t(265); chk("rd15_r_ad", R_AD, 16'h8000);
    go_t(271); chk("rd15_ref", REF_WWL, 1'b1); chk("rd_before", RD_DONE_LED, 1'b0);
    go_t(272); chk("rd_done", RD_DONE_LED, 1'b1); chk("wt_hold", WT_DONE_LED, 1'b1);
    chk("cnt_wri", n_wri - s_wri, 64);
    chk("cnt_dv", n_dv - s_dv, 16);
    chk("cnt_vsa", n_vsa - s_vsa, 64);
    chk("cnt_ref", n_ref - s_ref, 16);
    go_t(280);

    // Read-only restart from DONE
    sw[12] = 1'b1;
    s_wri = n_wri; s_dv = n_dv; s_vsa = n_vsa; s_ref = n_ref;
    press_to_t0();
    chk("ro_rd_clear", RD_DONE_LED, 1'b0);
    chk("ro_wt_clear", WT_DONE_LED, 1'b0);
    chk("ro_r_ad0", R_AD, 16'h0001);
    go_t(10); btn = 1'b1;
    go_t(112); chk("ro_rd_done", RD_DONE_LED, 1'b1); chk("ro_wt", WT_DONE_LED, 1'b0);
    chk("ro_cnt_wri", n_wri - s_wri, 0);
    chk("ro_cnt_dv", n_dv - s_dv, 0);
    chk("ro_cnt_vsa", n_vsa - s_vsa, 64);
    chk("ro_cnt_ref", n_ref - s_ref, 16);
    go_t(120);

    // Reset in the middle of the read phase
    sw[12] = 1'b0;
    press_to_t0();
    go_t(10); btn = 1'b1;
    go_t(200); chk("mid_r_ad", R_AD, 16'h0020); chk("mid_wt", WT_DONE_LED, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_r_ad", R_AD, 16'h0);
    chk("abort_rd_en", RD_EN, 1'b0);
    chk("abort_wt", WT_DONE_LED, 1'b0);
    chk("abort_d_in", D_IN, 16'h0);
    chk("abort_clk_out", clk_out, 1'b0);
    chk("abort_txd", uart_txd, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_idle_wri", WRI_EN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_wr_rd_sequencer.md
Name: dram_wr_rd_sequencer

Overview:
- FPGA-side test sequencer for a 16-word x 16-bit DRAM macro.
- A debounced active-low push-button starts a sequence that writes a known pattern to all 16 words through a serial-address/parallel-data write port.
- It then reads every word back through a one-hot read port.
- Status is shown on two done LEDs; static macro trims are driven from switches.

Parameters:
- DEBOUNCE_CYC, 1000000, consecutive low cycles of the synchronized button needed to accept a press (10 ms at 100 MHz).
- WR_PULSE_CYC, 4, cycles WRI_EN stays high per word.
- SENSE_CYC, 4, cycles VSAEN stays high per read.
- BAUD_DIV, 868, clk cycles per UART bit (115200 baud at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- IO_EN_button  in  1  start button, active-low, asynchronous.
- DRAM16_data  in  16  read data from the macro.
- SW2..SW12  in  1 each  static configuration switches.
- RD_DONE_LED, WT_DONE_LED  out  1  read-complete / write-complete, sticky.
- PC_data  out  3  = {SW6,SW5,SW4}.
- PC_D_IN  out  2  = {SW8,SW7}.
- PC_R_AD  out  2  = {SW10,SW9}.
- LIM_SEL  out  2  = {SW3,SW2}.
- DE_ADD3  out  1  = SW11.
- LIM_IN  out  16  = 16'h0000.
- ADD_IN, ADD_VALID_IN  out  1  serial write address bit and its valid.
- D_IN  out  16  write data.
- DATA_VALID_IN  out  1  write-data strobe.
- WRI_EN  out  1  write pulse.
- R_AD  out  16  one-hot read word select.
- RD_EN, VSAEN, REF_WWL  out  1  read enable, sense-amp enable, reference word line.
- clk_out  out  1  clk/2 forwarded clock.
- uart_txd  out  1  UART transmit, idles high.

Behaviour:
- Reset values: all outputs 0, except uart_txd=1. Switch pass-throughs stay combinational. FSM returns to IDLE. Any reset mid-sequence aborts immediately.
- clk_out: toggle flip-flop, free-running after reset.
- Button path:
  - 2-FF synchronizer, then a counter that must see DEBOUNCE_CYC consecutive low samples.
  - Generates a single start pulse per press. Re-arms only after the synchronized input returns high.
  - Presses while not IDLE/DONE are ignored.
- Start pulse clears both LEDs. If SW12=0, go to WR_ADDR with addr=0; if SW12=1 (read-only), go directly to RD_SETUP with addr=0.
- Write word, addr 0..15:
  - WR_ADDR: 4 cycles; ADD_VALID_IN=1, ADD_IN=addr bits MSB first.
  - WR_DATA: 1 cycle; DATA_VALID_IN=1, D_IN={addr,~addr,addr,~addr}, held until the next WR_DATA.
  - WR_PULSE: WRI_EN=1 for WR_PULSE_CYC cycles.
  - WR_GAP: 1 idle cycle.
  - Total 10 cycles/word at defaults.
- After addr=15 WR_GAP: WT_DONE_LED<=1, addr<=0, go to RD_SETUP.
- Read word:
  - RD_SETUP: 1 cycle; R_AD=1<<addr, RD_EN=1. R_AD and RD_EN stay asserted through RD_CAPTURE.
  - RD_SENSE: VSAEN=1 for SENSE_CYC cycles.
  - RD_CAPTURE: 1 cycle; DRAM16_data sampled into the capture register.
  - RD_REF: 1 cycle; REF_WWL=1, R_AD=0, RD_EN=0.
- After addr=15 (and UART drained if enabled): RD_DONE_LED<=1, state DONE.
- A new press from DONE restarts the sequence. Address counter wraps 15→0 only at phase change.

Optional Feature:
- UART_REPORT_EN: when defined, each captured word is sent as two 8N1 bytes, high byte first, LSB first, BAUD_DIV cycles per bit. The FSM waits in RD_TX until both bytes finish before RD_REF.
- When undefined, uart_txd is tied 1 and RD_TX is skipped.

Test Plan:
- Reset: rst high 100 ns with SWs 0 -> all outputs 0, uart_txd=1, clk_out held 0; after release clk_out period 20 ns.
- Switch pass-through: SW2..SW12 patterns -> LIM_SEL, PC_data, PC_D_IN, PC_R_AD, DE_ADD3 follow combinationally; LIM_IN=0000.
- Button held low 11 ms (DEBOUNCE_CYC=1e6) -> write starts:
  - word0 ADD_IN 0,0,0,0, D_IN=0F0F.
  - word5 ADD_IN 0,1,0,1, D_IN=5A5A.
  - WRI_EN 4 cycles per word.
  - WT_DONE_LED rises 160 cycles after the start pulse.
- Glitch: button low 500 cycles then high -> no start, LEDs stay 0.
- Read phase, DRAM16_data=A5A5:
  - R_AD walks 0001..8000; VSAEN 4 cycles per word; REF_WWL one pulse per word.
  - With UART_REPORT_EN, bytes A5,A5 per word.
  - RD_DONE_LED=1 at end.
- SW12=1 press -> no WRI_EN/DATA_VALID_IN activity; WT_DONE_LED stays 0, RD_DONE_LED=1. Reset asserted mid-read -> all outputs return to reset values within one clk.
